// File: rtl/reg_pipe_pkg.sv
// Shared constants for the cipher datapath pipeline registers.
package reg_pipe_pkg;

    localparam int unsigned BLOCK_W = 128;

endpackage : reg_pipe_pkg

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: a valid bit and a data register with a ready chain.
module reg_pipe_stage #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             up_ready_o,
    input  logic             dn_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             load;

    // Ready is combinational through the stage, so bubbles collapse in one cycle.
    assign up_ready_o = !vld_q || dn_ready_i;
    assign load       = up_ready_o && up_valid_i;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (up_ready_o) begin
            vld_d = up_valid_i;
            if (load) begin
                dat_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign valid_o = vld_q;
    assign data_o  = dat_q;

endmodule : reg_pipe_stage

// File: rtl/reg_pipe.sv
// Elastic valid/ready pipeline register of DEPTH stages with flush and occupancy count.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = BLOCK_W,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] count_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("reg_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] stage_rdy;
    logic [WIDTH-1:0] dat [DEPTH];

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;

        if (s == 0) begin : g_first
            assign up_valid = in_valid_i;
            assign up_data  = in_data_i;
        end else begin : g_mid_in
            assign up_valid = vld[s-1];
            assign up_data  = dat[s-1];
        end

        if (s == DEPTH - 1) begin : g_last
            assign dn_ready = out_ready_i;
        end else begin : g_mid_out
            assign dn_ready = stage_rdy[s+1];
        end

        reg_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .flush_i    (flush_i),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .up_ready_o (stage_rdy[s]),
            .dn_ready_i (dn_ready),
            .valid_o    (vld[s]),
            .data_o     (dat[s])
        );
    end

    assign in_ready_o  = stage_rdy[0] && !flush_i;
    assign out_valid_o = vld[DEPTH-1];
    assign out_data_o  = dat[DEPTH-1];

    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    // Internal stage-to-stage moves conserve occupancy, so only the two ends matter.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : reg_pipe

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: directed scenarios plus random traffic with a scoreboard.
module tb_reg_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default 128-bit, DEPTH=2.
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic [1:0]   a_count;

    // DUT B: 8-bit, DEPTH=1.
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]   b_in_data, b_out_data;
    logic [0:0]   b_count;

    reg_pipe #(.WIDTH(128), .DEPTH(2)) u_dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (a_flush),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (a_in_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_data_o  (a_out_data),
        .count_o     (a_count)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1)) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (b_flush),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data),
        .count_o     (b_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [127:0] sb [$];
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;

    // Scoreboard for DUT A: evaluated mid-cycle, for the transfers the next edge will perform.
    always @(negedge clk) begin
        logic [127:0] exp_beat;
        check("a_count_vs_sb", 128'(a_count), 128'(sb.size()));
        if (prev_stall && rst_n) begin
            check("a_stall_valid", 128'(a_out_valid), 128'd1);
            check("a_stall_data", a_out_data, prev_data);
        end
        if (a_out_valid && a_out_ready && rst_n) begin
            check("a_sb_nonempty", 128'(sb.size() > 0), 128'd1);
            if (sb.size() > 0) begin
                exp_beat = sb.pop_front();
                check("a_sb_data", a_out_data, exp_beat);
            end
        end
        if (a_flush) sb.delete();
        if (a_in_valid && a_in_ready && rst_n) sb.push_back(a_in_data);
        prev_stall = a_out_valid && !a_out_ready && !a_flush && rst_n;
        prev_data  = a_out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic a_drive(input logic v, input logic [127:0] d, input logic ordy);
        step();
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = ordy;
    endtask

    initial begin
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        repeat (3) step();
        mid();
        check("rst_out_valid", 128'(a_out_valid), 128'd0);
        check("rst_out_data", a_out_data, 128'd0);
        check("rst_count", 128'(a_count), 128'd0);
        step();
        rst_n = 1'b1;
        mid();
        check("rst_in_ready", 128'(a_in_ready), 128'd1);

        // Streaming: first beat out two cycles after acceptance, then one per cycle.
        a_drive(1, {4'hA, 124'h0}, 1);
        mid(); check("str_in_ready", 128'(a_in_ready), 128'd1);
        check("str_lat0", 128'(a_out_valid), 128'd0);
        a_drive(1, {4'hB, 124'h0}, 1);
        mid(); check("str_lat1", 128'(a_out_valid), 128'd0);
        a_drive(1, {4'hC, 124'h0}, 1);
        mid(); check("str_first_valid", 128'(a_out_valid), 128'd1);
        check("str_first_data", a_out_data, {4'hA, 124'h0});
        check("str_count_c2", 128'(a_count), 128'd2);
        a_drive(0, '0, 1);
        mid(); check("str_second_data", a_out_data, {4'hB, 124'h0});
        check("str_count_c3", 128'(a_count), 128'd2);
        a_drive(0, '0, 1);
        mid(); check("str_third_data", a_out_data, {4'hC, 124'h0});
        repeat (2) step();
        mid(); check("str_empty", 128'(a_out_valid), 128'd0);

        // Backpressure: fill, verify refusal and stable output, then drain in order.
        a_drive(1, 128'h11, 0);
        a_drive(1, 128'h22, 0);
        mid(); check("bp_in_ready_2nd", 128'(a_in_ready), 128'd1);
        a_drive(1, 128'h99, 0);
        mid(); check("bp_in_ready_full", 128'(a_in_ready), 128'd0);
        check("bp_count_full", 128'(a_count), 128'd2);
        check("bp_out_data", a_out_data, 128'h11);
        step(); mid(); check("bp_out_hold", a_out_data, 128'h11);
        a_drive(0, '0, 1);
        repeat (3) step();
        mid(); check("bp_drained", 128'(a_count), 128'd0);

        // Bubble collapse: a single beat advances to the output stage under stall.
        a_drive(1, 128'h44, 0);
        a_drive(0, '0, 0);
        mid(); check("bc_count1", 128'(a_count), 128'd1);
        check("bc_in_ready_s0", 128'(a_in_ready), 128'd1);
        check("bc_not_out_yet", 128'(a_out_valid), 128'd0);
        step();
        mid(); check("bc_out_valid", 128'(a_out_valid), 128'd1);
        check("bc_out_data", a_out_data, 128'h44);
        check("bc_in_ready_s1", 128'(a_in_ready), 128'd1);
        a_drive(1, 128'h55, 0);
        a_drive(0, '0, 0);
        mid(); check("bc_full_ready", 128'(a_in_ready), 128'd0);
        check("bc_full_count", 128'(a_count), 128'd2);

        // Flush with a competing input beat that must be dropped.
        step();
        a_flush = 1; a_in_valid = 1; a_in_data = 128'h33;
        mid(); check("fl_in_ready", 128'(a_in_ready), 128'd0);
        check("fl_pre_valid", 128'(a_out_valid), 128'd1);
        step();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        mid(); check("fl_count", 128'(a_count), 128'd0);
        check("fl_out_valid", 128'(a_out_valid), 128'd0);
        repeat (3) step();
        mid(); check("fl_no_33", 128'(a_out_valid), 128'd0);

        // Reset mid-stream with two beats held.
        a_drive(1, 128'h66, 0);
        a_drive(1, 128'h77, 0);
        a_drive(0, '0, 0);
        mid(); check("rs_count_pre", 128'(a_count), 128'd2);
        step();
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rs_out_valid", 128'(a_out_valid), 128'd0);
        check("rs_out_data", a_out_data, 128'd0);
        check("rs_count", 128'(a_count), 128'd0);
        step();
        rst_n = 1'b1;
        mid(); check("rs_in_ready", 128'(a_in_ready), 128'd1);

        // DEPTH=1 pass-through while full.
        step();
        b_in_valid = 1; b_in_data = 8'hA5; b_out_ready = 0;
        step();
        b_in_valid = 0;
        mid(); check("pt_full_ready", 128'(b_in_ready), 128'd0);
        check("pt_full_count", 128'(b_count), 128'd1);
        step();
        b_in_valid = 1; b_in_data = 8'h5A; b_out_ready = 1;
        mid(); check("pt_in_ready", 128'(b_in_ready), 128'd1);
        check("pt_old_data", 128'(b_out_data), 128'hA5);
        step();
        b_in_valid = 0;
        mid(); check("pt_new_data", 128'(b_out_data), 128'h5A);
        check("pt_new_valid", 128'(b_out_valid), 128'd1);
        check("pt_count", 128'(b_count), 128'd1);
        step();
        mid(); check("pt_empty", 128'(b_count), 128'd0);

        // Random traffic on DUT A, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            step();
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_in_data   = {$urandom, $urandom, $urandom, $urandom};
            a_flush     = ($urandom_range(0, 31) == 0);
        end
        step();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        repeat (4) step();
        mid(); check("rnd_drain_count", 128'(a_count), 128'd0);
        check("rnd_sb_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_pipe
